// File: rtl/colsched_pkg.sv
// colsched_pkg -- shared definitions for the colour slot scheduler.
//   * image processor register offsets driven over the Avalon-MM master
//   * CPU slave register offsets (single registers and 4-entry slot groups)
//   * FSM state encoding
//   * maximum number of colour slots supported by the address map
package colsched_pkg;

  localparam int NUM_SLOTS_MAX = 4;
  localparam int SLOT_W        = 2;

  // Image processor register port (word addresses)
  localparam logic [3:0] IP_THR_LOW  = 4'd4;
  localparam logic [3:0] IP_THR_UP   = 4'd5;
  localparam logic [3:0] IP_COM_X    = 4'd7;
  localparam logic [3:0] IP_COM_Y    = 4'd8;
  localparam logic [3:0] IP_COM_MASS = 4'd9;

  // CPU slave single registers
  localparam logic [4:0] CPU_CTRL   = 5'd0;
  localparam logic [4:0] CPU_STATUS = 5'd1;
  localparam logic [4:0] CPU_VALID  = 5'd2;

  // CPU slave per-slot groups, selected by address[4:2]; address[1:0] is the slot
  localparam logic [2:0] CPU_GRP_THR_LO = 3'd1;
  localparam logic [2:0] CPU_GRP_THR_UP = 3'd2;
  localparam logic [2:0] CPU_GRP_COM_X  = 3'd3;
  localparam logic [2:0] CPU_GRP_COM_Y  = 3'd4;
  localparam logic [2:0] CPU_GRP_MASS   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_X,
    ST_RD_Y,
    ST_RD_M,
    ST_CAP_M,
    ST_WR_LO,
    ST_WR_UP
  } state_t;

endpackage

// File: rtl/colsched_next_slot.sv
// colsched_next_slot -- combinational round-robin next-set-bit finder.
//   i_mask [3:0]  enabled slots
//   i_cur  [1:0]  current slot
//   o_next [1:0]  first set bit strictly after i_cur, wrapping; i_cur itself
//                 is the last candidate, so a lone bit selects itself.
//                 With an empty mask o_next holds i_cur.
//   o_wrap        selected slot index is lower than or equal to i_cur
module colsched_next_slot
  import colsched_pkg::*;
(
  input  logic [NUM_SLOTS_MAX-1:0] i_mask,
  input  logic [SLOT_W-1:0]        i_cur,
  output logic [SLOT_W-1:0]        o_next,
  output logic                     o_wrap
);

  logic [SLOT_W-1:0]        w_cand [NUM_SLOTS_MAX];
  logic [NUM_SLOTS_MAX-1:0] w_hit;

  // Candidate gi is the slot gi+1 positions after i_cur (modulo the slot count).
  genvar gi;
  for (gi = 0; gi < NUM_SLOTS_MAX; gi++) begin : g_cand
    assign w_cand[gi] = i_cur + SLOT_W'(gi + 1);
    assign w_hit[gi]  = i_mask[w_cand[gi]];
  end

  // Scan from the farthest candidate down so the nearest hit is assigned last.
  always_comb begin
    o_next = i_cur;
    o_wrap = 1'b0;
    for (int k = NUM_SLOTS_MAX - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_next = w_cand[k];
        o_wrap = (w_cand[k] <= i_cur);
      end
    end
  end

endmodule

// File: rtl/colour_slot_scheduler.sv
// colour_slot_scheduler -- time-multiplexes the image processor's threshold /
// centre-of-mass datapath across up to NUM_SLOTS colour classes, one per frame.
// On each frame_done the results of the class just measured are read back
// (skipped on the first frame after enable), then the next class's thresholds
// are programmed.
//   clk, reset_n        clock, synchronous active-low reset
//   frame_done          one-cycle end-of-video-frame pulse
//   s_*                 CPU Avalon-MM slave (5-bit word address, registered read)
//   m_*                 Avalon-MM master to the image processor register port
//   irq                 round-complete interrupt, only when COLSCHED_IRQ_EN is defined
module colour_slot_scheduler
  import colsched_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_done,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [4:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [3:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata
`ifdef COLSCHED_IRQ_EN
  ,
  output logic        irq
`endif
);

  state_t                   r_state, w_state_next;
  logic                     r_enable, r_primed;
  logic [NUM_SLOTS_MAX-1:0] r_slot_mask, r_valid, w_valid_next, w_eff_mask;
  logic [SLOT_W-1:0]        r_cur_slot, w_next_slot, w_idx;
  logic [7:0]               r_round_cnt;
  logic [15:0]              r_overrun_cnt;
  logic [23:0]              r_thr_low [NUM_SLOTS_MAX];
  logic [23:0]              r_thr_up  [NUM_SLOTS_MAX];
  logic [31:0]              r_com_x   [NUM_SLOTS_MAX];
  logic [31:0]              r_com_y   [NUM_SLOTS_MAX];
  logic [31:0]              r_mass    [NUM_SLOTS_MAX];
  logic [31:0]              r_readdata, w_rdata;
  logic                     w_wrap, w_round_inc, w_cpu_wr, w_cpu_rd, w_irq_pending;
  logic                     w_unused_wdata;

  assign w_cpu_wr       = s_chipselect & s_write;
  assign w_cpu_rd       = s_chipselect & s_read;
  assign w_idx          = s_address[1:0];
  assign s_readdata     = r_readdata;
  assign w_unused_wdata = ^s_writedata[31:24];

  // Slots beyond NUM_SLOTS are never scheduled, whatever the CPU writes.
  genvar gi;
  for (gi = 0; gi < NUM_SLOTS_MAX; gi++) begin : g_mask
    if (gi < NUM_SLOTS) begin : g_on
      assign w_eff_mask[gi] = r_slot_mask[gi];
    end else begin : g_off
      assign w_eff_mask[gi] = 1'b0;
    end
  end

  colsched_next_slot u_next_slot (
    .i_mask (w_eff_mask),
    .i_cur  (r_cur_slot),
    .o_next (w_next_slot),
    .o_wrap (w_wrap)
  );

  assign w_round_inc = (r_state == ST_CAP_M) && w_wrap;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    m_chipselect = 1'b0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = '0;
    m_writedata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (frame_done && r_enable && (w_eff_mask != '0))
          w_state_next = r_primed ? ST_RD_X : ST_WR_LO;
      end
      ST_RD_X: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = IP_COM_X;
        w_state_next = ST_RD_Y;
      end
      ST_RD_Y: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = IP_COM_Y;
        w_state_next = ST_RD_M;
      end
      ST_RD_M: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = IP_COM_MASS;
        w_state_next = ST_CAP_M;
      end
      ST_CAP_M: w_state_next = ST_WR_LO;
      ST_WR_LO: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = IP_THR_LOW;
        m_writedata  = {8'd0, r_thr_low[r_cur_slot]};
        w_state_next = ST_WR_UP;
      end
      ST_WR_UP: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = IP_THR_UP;
        m_writedata  = {8'd0, r_thr_up[r_cur_slot]};
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Sticky result-valid bits: a new result wins over a same-cycle clear.
  always_comb begin
    w_valid_next = r_valid;
    if (w_cpu_wr && (s_address == CPU_VALID))
      w_valid_next = w_valid_next & ~s_writedata[NUM_SLOTS_MAX-1:0];
    if (r_state == ST_CAP_M)
      w_valid_next[r_cur_slot] = 1'b1;
  end

`ifdef COLSCHED_IRQ_EN
  logic r_irq;
  // Set has priority so a round completing during a clear is not lost.
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_irq <= 1'b0;
    else if (w_round_inc)
      r_irq <= 1'b1;
    else if (w_cpu_wr && (s_address == CPU_VALID) && s_writedata[4])
      r_irq <= 1'b0;
  end
  assign irq           = r_irq;
  assign w_irq_pending = r_irq;
`else
  assign w_irq_pending = 1'b0;
`endif

  // ---------------- CPU read mux ----------------
  always_comb begin
    w_rdata = '0;
    case (s_address)
      CPU_CTRL:   w_rdata = {20'd0, r_slot_mask, 7'd0, r_enable};
      CPU_STATUS: w_rdata = {r_overrun_cnt, r_round_cnt, 6'd0, r_cur_slot};
      CPU_VALID:  w_rdata = {27'd0, w_irq_pending, r_valid};
      default: begin
        case (s_address[4:2])
          CPU_GRP_THR_LO: w_rdata = {8'd0, r_thr_low[w_idx]};
          CPU_GRP_THR_UP: w_rdata = {8'd0, r_thr_up[w_idx]};
          CPU_GRP_COM_X:  w_rdata = r_com_x[w_idx];
          CPU_GRP_COM_Y:  w_rdata = r_com_y[w_idx];
          CPU_GRP_MASS:   w_rdata = r_mass[w_idx];
          default:        w_rdata = '0;
        endcase
      end
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_enable      <= 1'b0;
      r_slot_mask   <= '0;
      r_primed      <= 1'b0;
      r_cur_slot    <= '0;
      r_round_cnt   <= '0;
      r_overrun_cnt <= '0;
      r_valid       <= '0;
      r_readdata    <= '0;
      for (int k = 0; k < NUM_SLOTS_MAX; k++) begin
        r_thr_low[k] <= '0;
        r_thr_up[k]  <= '0;
        r_com_x[k]   <= '0;
        r_com_y[k]   <= '0;
        r_mass[k]    <= '0;
      end
    end else begin
      r_valid <= w_valid_next;
      if (w_cpu_rd) r_readdata <= w_rdata;

      if (w_cpu_wr) begin
        if (s_address == CPU_CTRL) begin
          r_enable    <= s_writedata[0];
          r_slot_mask <= s_writedata[11:8];
        end
        if (s_address[4:2] == CPU_GRP_THR_LO) r_thr_low[w_idx] <= s_writedata[23:0];
        if (s_address[4:2] == CPU_GRP_THR_UP) r_thr_up[w_idx]  <= s_writedata[23:0];
      end

      // A frame ending while a sequence is still running is dropped and counted.
      if (frame_done && (r_state != ST_IDLE) && (r_overrun_cnt != 16'hFFFF))
        r_overrun_cnt <= r_overrun_cnt + 16'd1;

      // Each read result arrives the cycle after its m_read.
      case (r_state)
        ST_RD_Y:  r_com_x[r_cur_slot] <= m_readdata;
        ST_RD_M:  r_com_y[r_cur_slot] <= m_readdata;
        ST_CAP_M: begin
          r_mass[r_cur_slot] <= m_readdata;
          r_cur_slot         <= w_next_slot;
        end
        ST_WR_UP: r_primed <= 1'b1;
        default: ;
      endcase

      if (w_round_inc) r_round_cnt <= r_round_cnt + 8'd1;

      // Re-enabling discards the stale programming: next frame is program-only.
      if (w_cpu_wr && (s_address == CPU_CTRL) && s_writedata[0] && !r_enable)
        r_primed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_colour_slot_scheduler.sv
module tb_colour_slot_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_done = 1'b0;
  logic        s_chipselect = 1'b0, s_read = 1'b0, s_write = 1'b0;
  logic [4:0]  s_address = '0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        m_chipselect, m_read, m_write;
  logic [3:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = '0;
`ifdef COLSCHED_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        cs;
    logic        wr;
    logic        rd;
    logic [3:0]  a;
    logic [31:0] d;
    int          c;
  } txn_t;
  txn_t        log_q[$];
  logic [31:0] ip_reg [16];
  logic        rd_pend = 1'b0;
  logic [3:0]  rd_addr = '0;

  colour_slot_scheduler #(.NUM_SLOTS(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_done   (frame_done),
    .s_chipselect (s_chipselect),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_address    (s_address),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .m_chipselect (m_chipselect),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata)
`ifdef COLSCHED_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Master-side observer: log every strobe cycle and remember reads.
  always @(negedge clk) begin
    if (m_chipselect || m_read || m_write) begin
      log_q.push_back('{m_chipselect, m_write, m_read, m_address, m_writedata, cyc});
      $display("master %s addr=%0d data=0x%08h cyc=%0d", m_write ? "wr" : "rd",
               m_address, m_writedata, cyc);
    end
    rd_pend = m_chipselect && m_read;
    rd_addr = m_address;
  end

  // Image processor model: read data valid the cycle after m_read.
  always @(posedge clk) begin
    #1;
    m_readdata = rd_pend ? ip_reg[rd_addr] : 32'h0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    step();
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [4:0] a, output logic [31:0] d);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    step();
    s_chipselect = 1'b0; s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic pulse_frame(output int f);
    f = cyc;
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [4:0]  addrs [5] = '{5'd0, 5'd1, 5'd2, 5'd12, 5'd20};
    do_reset();
    total++;
    if ({m_chipselect, m_read, m_write, m_address, m_writedata} !== 39'd0) begin
      bad++; $display("FAIL reset_master got cs=%b rd=%b wr=%b a=%0d d=0x%08h want all 0",
                      m_chipselect, m_read, m_write, m_address, m_writedata);
    end
    total++;
    if (s_readdata !== 32'h0) begin
      bad++; $display("FAIL reset_readdata got 0x%08h want 0", s_readdata);
    end
`ifdef COLSCHED_IRQ_EN
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", irq); end
`endif
    for (int i = 0; i < 5; i++) begin
      cpu_read(addrs[i], rd);
      total++;
      if (rd !== 32'h0) begin
        bad++; $display("FAIL reset_reg addr=%0d got 0x%08h want 0", addrs[i], rd);
      end
    end
  endtask

  task automatic test_program();
    logic [31:0] rd;
    int f;
    cpu_write(5'd4, 32'h0080_0000);
    cpu_write(5'd8, 32'h00FF_7F7F);
    cpu_write(5'd6, 32'h0011_1111);
    cpu_write(5'd10, 32'h0022_2222);
    cpu_write(5'd0, 32'h0000_0501);
    cpu_read(5'd0, rd);
    total++;
    if (rd !== 32'h0000_0501) begin bad++; $display("FAIL ctrl_readback got 0x%08h want 0x00000501", rd); end
    cpu_read(5'd8, rd);
    total++;
    if (rd !== 32'h00FF_7F7F) begin bad++; $display("FAIL thr_up0_readback got 0x%08h want 0x00ff7f7f", rd); end
    cpu_read(5'd3, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL unmapped3 got 0x%08h want 0", rd); end
    cpu_read(5'd30, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL unmapped30 got 0x%08h want 0", rd); end
    log_q.delete();
    pulse_frame(f);
    repeat (8) step();
    total++;
    if (log_q.size() != 2) begin bad++; $display("FAIL prog_count got %0d want 2", log_q.size()); end
    if (log_q.size() >= 2) begin
      total++;
      if ({log_q[0].cs, log_q[0].wr, log_q[0].rd, log_q[0].a, log_q[0].d} !== {3'b110, 4'd4, 32'h0080_0000}
          || log_q[0].c != f + 1) begin
        bad++; $display("FAIL prog_wr_lo got wr=%b a=%0d d=0x%08h c=%0d want wr=1 a=4 d=0x00800000 c=%0d",
                        log_q[0].wr, log_q[0].a, log_q[0].d, log_q[0].c, f + 1);
      end
      total++;
      if ({log_q[1].cs, log_q[1].wr, log_q[1].rd, log_q[1].a, log_q[1].d} !== {3'b110, 4'd5, 32'h00FF_7F7F}
          || log_q[1].c != f + 2) begin
        bad++; $display("FAIL prog_wr_up got wr=%b a=%0d d=0x%08h c=%0d want wr=1 a=5 d=0x00ff7f7f c=%0d",
                        log_q[1].wr, log_q[1].a, log_q[1].d, log_q[1].c, f + 2);
      end
    end
    cpu_read(5'd1, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL prog_status got 0x%08h want 0", rd); end
  endtask

  task automatic test_measure();
    logic [31:0] rd;
    int f;
    logic        ew [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  ea [5] = '{4'd7, 4'd8, 4'd9, 4'd4, 4'd5};
    logic [31:0] ed [5] = '{32'h0, 32'h0, 32'h0, 32'h0011_1111, 32'h0022_2222};
    int          ec [5] = '{1, 2, 3, 5, 6};
    logic [4:0]  ra [4] = '{5'd12, 5'd16, 5'd2, 5'd1};
    logic [31:0] rv [4] = '{32'h100, 32'h200, 32'h1, 32'h2};
    ip_reg[7] = 32'h100; ip_reg[8] = 32'h200; ip_reg[9] = 32'h300;
    log_q.delete();
    pulse_frame(f);
    repeat (4) step();
    cpu_read(5'd20, rd);  // issued the cycle after CAP_M
    total++;
    if (rd !== 32'h300) begin bad++; $display("FAIL mass_visible got 0x%08h want 0x300", rd); end
    repeat (4) step();
    total++;
    if (log_q.size() != 5) begin bad++; $display("FAIL meas_count got %0d want 5", log_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < log_q.size()) begin
        total++;
        if ({log_q[i].cs, log_q[i].wr, log_q[i].rd, log_q[i].a, (log_q[i].wr ? log_q[i].d : 32'h0)}
              !== {1'b1, ew[i], ~ew[i], ea[i], ed[i]} || log_q[i].c != f + ec[i]) begin
          bad++; $display("FAIL meas_txn%0d got wr=%b rd=%b a=%0d d=0x%08h c=%0d want wr=%b a=%0d d=0x%08h c=%0d",
                          i, log_q[i].wr, log_q[i].rd, log_q[i].a, log_q[i].d, log_q[i].c,
                          ew[i], ea[i], ed[i], f + ec[i]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      cpu_read(ra[i], rd);
      total++;
      if (rd !== rv[i]) begin bad++; $display("FAIL meas_reg addr=%0d got 0x%08h want 0x%08h", ra[i], rd, rv[i]); end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] rd;
    int f;
    logic [1:0] exp_cur [4] = '{2'd3, 2'd0, 2'd3, 2'd0};
    do_reset();
    cpu_write(5'd4, 32'h000A_0A0A);
    cpu_write(5'd8, 32'h000B_0B0B);
    cpu_write(5'd7, 32'h0033_3333);
    cpu_write(5'd11, 32'h0044_4444);
    cpu_write(5'd0, 32'h0000_0901);
    pulse_frame(f);
    repeat (6) step();
    for (int n = 1; n <= 4; n++) begin
      ip_reg[7] = 32'h1000 + 32'(n);
      log_q.delete();
      pulse_frame(f);
      repeat (8) step();
      cpu_read(5'd1, rd);
      total++;
      if (rd[1:0] !== exp_cur[n-1]) begin
        bad++; $display("FAIL rr_cur frame=%0d got %0d want %0d", n, rd[1:0], exp_cur[n-1]);
      end
      total++;
      if (log_q.size() != 5) begin
        bad++; $display("FAIL rr_count frame=%0d got %0d want 5", n, log_q.size());
      end else if (log_q[3].d !== ((exp_cur[n-1] == 2'd3) ? 32'h0033_3333 : 32'h000A_0A0A)
                   || log_q[4].d !== ((exp_cur[n-1] == 2'd3) ? 32'h0044_4444 : 32'h000B_0B0B)) begin
        bad++; $display("FAIL rr_thr frame=%0d got lo=0x%08h up=0x%08h for slot %0d",
                        n, log_q[3].d, log_q[4].d, exp_cur[n-1]);
      end
    end
    cpu_read(5'd1, rd);
    total++;
    if (rd[15:8] !== 8'd2) begin bad++; $display("FAIL rr_round got %0d want 2", rd[15:8]); end
    cpu_read(5'd12, rd);
    total++;
    if (rd !== 32'h1003) begin bad++; $display("FAIL rr_comx0 got 0x%08h want 0x1003", rd); end
    cpu_read(5'd15, rd);
    total++;
    if (rd !== 32'h1004) begin bad++; $display("FAIL rr_comx3 got 0x%08h want 0x1004", rd); end
    cpu_read(5'd2, rd);
    total++;
    if (rd !== 32'h9) begin bad++; $display("FAIL rr_valid got 0x%08h want 0x9", rd); end
  endtask

  // Continues from round robin: primed, cur_slot 0, mask 1001.
  task automatic test_overrun();
    logic [31:0] rd;
    int f, g;
    logic        ew [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  ea [5] = '{4'd7, 4'd8, 4'd9, 4'd4, 4'd5};
    logic [31:0] ed [5] = '{32'h0, 32'h0, 32'h0, 32'h0033_3333, 32'h0044_4444};
    int          ec [5] = '{1, 2, 3, 5, 6};
    log_q.delete();
    pulse_frame(f);
    step();
    pulse_frame(g);       // during RD_Y
    step(); step();
    pulse_frame(g);       // during WR_LO
    repeat (8) step();
    total++;
    if (log_q.size() != 5) begin bad++; $display("FAIL ovr_count got %0d want 5", log_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < log_q.size()) begin
        total++;
        if ({log_q[i].cs, log_q[i].wr, log_q[i].rd, log_q[i].a, (log_q[i].wr ? log_q[i].d : 32'h0)}
              !== {1'b1, ew[i], ~ew[i], ea[i], ed[i]} || log_q[i].c != f + ec[i]) begin
          bad++; $display("FAIL ovr_txn%0d got wr=%b rd=%b a=%0d d=0x%08h c=%0d want wr=%b a=%0d d=0x%08h c=%0d",
                          i, log_q[i].wr, log_q[i].rd, log_q[i].a, log_q[i].d, log_q[i].c,
                          ew[i], ea[i], ed[i], f + ec[i]);
        end
      end
    end
    cpu_read(5'd1, rd);
    total++;
    if (rd !== 32'h0002_0203) begin bad++; $display("FAIL ovr_status got 0x%08h want 0x00020203", rd); end
  endtask

  task automatic test_single_slot();
    logic [31:0] rd;
    int f;
    do_reset();
    cpu_write(5'd4, 32'h0012_3456);
    cpu_write(5'd8, 32'h0065_4321);
    cpu_write(5'd0, 32'h0000_0101);
    pulse_frame(f);
    repeat (6) step();
    log_q.delete();
    pulse_frame(f);
    repeat (4) step();
    cpu_write(5'd4, 32'h00AB_CDEF);  // lands during WR_LO
    repeat (6) step();
    total++;
    if (log_q.size() != 5 || log_q[3].d !== 32'h0012_3456 || log_q[4].d !== 32'h0065_4321) begin
      bad++; $display("FAIL single_old_thr count=%0d lo=0x%08h up=0x%08h want 5 0x00123456 0x00654321",
                      log_q.size(), (log_q.size() > 3) ? log_q[3].d : 32'h0,
                      (log_q.size() > 4) ? log_q[4].d : 32'h0);
    end
    cpu_read(5'd1, rd);
    total++;
    if (rd !== 32'h0000_0100) begin bad++; $display("FAIL single_status1 got 0x%08h want 0x00000100", rd); end
`ifdef COLSCHED_IRQ_EN
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got %b want 1", irq); end
    cpu_read(5'd2, rd);
    total++;
    if (rd !== 32'h11) begin bad++; $display("FAIL irq_valid got 0x%08h want 0x11", rd); end
    cpu_write(5'd2, 32'h10);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got %b want 0", irq); end
`endif
    cpu_read(5'd2, rd);
    total++;
    if (rd !== 32'h01) begin bad++; $display("FAIL single_valid got 0x%08h want 0x01", rd); end
    log_q.delete();
    pulse_frame(f);
    repeat (8) step();
    total++;
    if (log_q.size() != 5 || log_q[3].d !== 32'h00AB_CDEF) begin
      bad++; $display("FAIL single_new_thr count=%0d lo=0x%08h want 5 0x00abcdef",
                      log_q.size(), (log_q.size() > 3) ? log_q[3].d : 32'h0);
    end
    cpu_read(5'd1, rd);
    total++;
    if (rd !== 32'h0000_0200) begin bad++; $display("FAIL single_status2 got 0x%08h want 0x00000200", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int f;
    pulse_frame(f);   // primed from the previous test: RD_X next
    step(); step();   // now in RD_M
    reset_n = 1'b0;
    step();
    total++;
    if ({m_chipselect, m_read, m_write, m_address, m_writedata} !== 39'd0) begin
      bad++; $display("FAIL rstmid_master got cs=%b rd=%b wr=%b a=%0d want all 0",
                      m_chipselect, m_read, m_write, m_address);
    end
    step();
    reset_n = 1'b1;
    step();
    cpu_read(5'd1, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL rstmid_status got 0x%08h want 0", rd); end
    cpu_read(5'd12, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL rstmid_comx got 0x%08h want 0", rd); end
    cpu_write(5'd0, 32'h0000_0101);
    log_q.delete();
    pulse_frame(f);
    repeat (8) step();
    total++;
    if (log_q.size() != 2 || log_q[0].wr !== 1'b1 || log_q[0].a !== 4'd4 || log_q[0].d !== 32'h0) begin
      bad++; $display("FAIL rstmid_unprimed count=%0d first_wr=%b a=%0d want 2 writes from addr 4",
                      log_q.size(), (log_q.size() > 0) ? log_q[0].wr : 1'b0,
                      (log_q.size() > 0) ? log_q[0].a : 4'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ip_reg[i] = 32'h0;
    test_reset();
    test_program();
    test_measure();
    test_round_robin();
    test_overrun();
    test_single_slot();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
